// File: rtl/nes_mem_pkg.sv
// Shared definitions for the NES memory subsystem: slot owner encoding,
// slot phase marker and requester address width.
package nes_mem_pkg;

  localparam int         NES_ADDR_W     = 22;
  localparam logic [1:0] SLOT_END_PHASE = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU    = 2'd1,
    LOADER = 2'd2,
    BACKUP = 2'd3
  } owner_t;

endpackage

// File: rtl/porta_slot_timer.sv
// Slot boundary strobes derived from the NES phase counter: o_slot_end marks the
// last cycle of a slot, o_slot_start the first cycle of the following one.
module porta_slot_timer
  import nes_mem_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_nes_ce,
  output logic       o_slot_end,
  output logic       o_slot_start
);

  logic r_start;

  assign o_slot_end   = (i_nes_ce == SLOT_END_PHASE);
  assign o_slot_start = r_start;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_start <= 1'b0;
    else          r_start <= o_slot_end;
  end

endmodule

// File: rtl/sdram_porta_arbiter.sv
// SDRAM port A owner: grants 4-cycle slots to the CPU, the loader holding
// register or the battery-RAM backup port, and muxes the port accordingly.
module sdram_porta_arbiter
  import nes_mem_pkg::*;
#(
  parameter int ADDR_W      = 25,
  parameter bit LOADER_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            nes_ce,
  input  logic                  nes_running,
  input  logic [NES_ADDR_W-1:0] cpu_addr,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [7:0]            cpu_dout,
  output logic [7:0]            cpu_din,
  input  logic                  ld_wr,
  input  logic [NES_ADDR_W-1:0] ld_addr,
  input  logic [7:0]            ld_data,
  output logic                  ld_full,
  output logic                  ld_overrun,
  input  logic                  bk_req,
  input  logic                  bk_we,
  input  logic [NES_ADDR_W-1:0] bk_addr,
  input  logic [7:0]            bk_din,
  output logic [7:0]            bk_dout,
  output logic                  bk_ack,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [7:0]            mem_din,
  input  logic [7:0]            mem_dout,
  output logic [1:0]            owner
);

  localparam int PAD_W = ADDR_W - NES_ADDR_W;

  logic                  w_slot_end;
  logic                  w_slot_start;
  owner_t                r_owner;
  owner_t                w_next_owner;
  logic                  r_rr_bk;
  logic                  w_flip;
  logic                  r_ld_full;
  logic                  r_ld_overrun;
  logic [NES_ADDR_W-1:0] r_ld_addr;
  logic [7:0]            r_ld_data;
  logic [NES_ADDR_W-1:0] r_bk_addr;
  logic [7:0]            r_bk_din;
  logic                  r_bk_we;
  logic                  r_bk_ack;
  logic [7:0]            r_bk_dout;
  logic [ADDR_W-1:0]     r_addr_hold;
  logic [7:0]            r_din_hold;
  logic                  w_ld_clear;
  logic                  w_ld_take;
  logic                  w_ld_pend;
  logic                  w_bk_pend;
  logic [ADDR_W-1:0]     w_mem_addr;
  logic [7:0]            w_mem_din;
  logic                  w_mem_we;
  logic                  w_mem_oe;

  porta_slot_timer u_slot_timer (
    .i_clk        (clk),
    .i_rst_n      (reset_n),
    .i_nes_ce     (nes_ce),
    .o_slot_end   (w_slot_end),
    .o_slot_start (w_slot_start)
  );

  // A request being served in the slot that is ending is not pending for the next one.
  assign w_ld_clear = w_slot_end && (r_owner == LOADER);
  assign w_ld_take  = ld_wr && (!r_ld_full || w_ld_clear);
  assign w_ld_pend  = r_ld_full && !w_ld_clear;
  assign w_bk_pend  = bk_req && (r_owner != BACKUP);

  always_comb begin
    w_next_owner = IDLE;
    w_flip       = 1'b0;
    if (nes_running) begin
      w_next_owner = CPU;
    end else if (w_ld_pend && w_bk_pend) begin
      if (LOADER_PRIO) begin
        w_next_owner = LOADER;
      end else begin
        w_next_owner = r_rr_bk ? BACKUP : LOADER;
        w_flip       = 1'b1;
      end
    end else if (w_ld_pend) begin
      w_next_owner = LOADER;
    end else if (w_bk_pend) begin
      w_next_owner = BACKUP;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_owner      <= IDLE;
      r_rr_bk      <= 1'b0;
      r_ld_full    <= 1'b0;
      r_ld_overrun <= 1'b0;
      r_bk_ack     <= 1'b0;
      r_bk_dout    <= 8'h00;
      r_addr_hold  <= '0;
      r_din_hold   <= 8'h00;
    end else begin
      if (w_slot_end) begin
        r_owner <= w_next_owner;
        if (w_flip) r_rr_bk <= ~r_rr_bk;
      end
      if (w_ld_take)       r_ld_full <= 1'b1;
      else if (w_ld_clear) r_ld_full <= 1'b0;
      if (ld_wr && !w_ld_take) r_ld_overrun <= 1'b1;
      if (w_slot_end && (r_owner == BACKUP)) begin
        r_bk_ack <= 1'b1;
        if (!r_bk_we) r_bk_dout <= mem_dout;
      end else if (w_slot_start) begin
        r_bk_ack <= 1'b0;
      end
      // Remember the last driven address/data so an idle port stays quiet.
      if (r_owner != IDLE) begin
        r_addr_hold <= w_mem_addr;
        r_din_hold  <= w_mem_din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_ld_take) begin
      r_ld_addr <= ld_addr;
      r_ld_data <= ld_data;
    end
    if (w_slot_end && (w_next_owner == BACKUP)) begin
      r_bk_addr <= bk_addr;
      r_bk_din  <= bk_din;
      r_bk_we   <= bk_we;
    end
  end

  always_comb begin
    w_mem_addr = r_addr_hold;
    w_mem_din  = r_din_hold;
    w_mem_we   = 1'b0;
    w_mem_oe   = 1'b0;
    case (r_owner)
      CPU: begin
        w_mem_addr = {{PAD_W{1'b0}}, cpu_addr};
        w_mem_din  = cpu_dout;
        w_mem_we   = cpu_wr;
        w_mem_oe   = cpu_rd;
      end
      LOADER: begin
        w_mem_addr = {{PAD_W{1'b0}}, r_ld_addr};
        w_mem_din  = r_ld_data;
        w_mem_we   = 1'b1;
      end
      BACKUP: begin
        w_mem_addr = {{PAD_W{1'b0}}, r_bk_addr};
        w_mem_din  = r_bk_din;
        w_mem_we   = r_bk_we;
        w_mem_oe   = ~r_bk_we;
      end
      IDLE: ;
      default: ;
    endcase
  end

  assign mem_addr   = w_mem_addr;
  assign mem_din    = w_mem_din;
  assign mem_we     = w_mem_we;
  assign mem_oe     = w_mem_oe;
  assign cpu_din    = mem_dout;
  assign ld_full    = r_ld_full;
  assign ld_overrun = r_ld_overrun;
  assign bk_ack     = r_bk_ack;
  assign bk_dout    = r_bk_dout;
  assign owner      = r_owner;

endmodule

// File: tb/tb_sdram_porta_arbiter.sv
// Directed bench for sdram_porta_arbiter: one round-robin and one loader-priority
// instance share the same stimulus; slot phase is driven by the bench.
module tb_sdram_porta_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  nes_ce = 2'd0;
  logic        nes_running = 1'b0;
  logic [21:0] cpu_addr = '0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [7:0]  cpu_dout = '0;
  logic        ld_wr = 1'b0;
  logic [21:0] ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        bk_req = 1'b0, bk_we = 1'b0;
  logic [21:0] bk_addr = '0;
  logic [7:0]  bk_din = '0;
  logic [7:0]  mem_dout = '0;

  logic [7:0]  cpu_din0, cpu_din1, bk_dout0, bk_dout1, mem_din0, mem_din1;
  logic        ld_full0, ld_full1, ld_overrun0, ld_overrun1, bk_ack0, bk_ack1;
  logic        mem_we0, mem_we1, mem_oe0, mem_oe1;
  logic [24:0] mem_addr0, mem_addr1;
  logic [1:0]  owner0, owner1;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sdram_porta_arbiter #(.ADDR_W(25), .LOADER_PRIO(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .nes_ce(nes_ce), .nes_running(nes_running),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout), .cpu_din(cpu_din0),
    .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_full(ld_full0), .ld_overrun(ld_overrun0),
    .bk_req(bk_req), .bk_we(bk_we), .bk_addr(bk_addr), .bk_din(bk_din), .bk_dout(bk_dout0), .bk_ack(bk_ack0),
    .mem_addr(mem_addr0), .mem_we(mem_we0), .mem_oe(mem_oe0), .mem_din(mem_din0), .mem_dout(mem_dout),
    .owner(owner0)
  );

  sdram_porta_arbiter #(.ADDR_W(25), .LOADER_PRIO(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n), .nes_ce(nes_ce), .nes_running(nes_running),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout), .cpu_din(cpu_din1),
    .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data), .ld_full(ld_full1), .ld_overrun(ld_overrun1),
    .bk_req(bk_req), .bk_we(bk_we), .bk_addr(bk_addr), .bk_din(bk_din), .bk_dout(bk_dout1), .bk_ack(bk_ack1),
    .mem_addr(mem_addr1), .mem_we(mem_we1), .mem_oe(mem_oe1), .mem_din(mem_din1), .mem_dout(mem_dout),
    .owner(owner1)
  );

  typedef struct {
    logic [21:0] addr;
    logic        rd;
    logic        wr;
    logic [7:0]  dout;
    logic [7:0]  mdout;
    logic [24:0] e_addr;
    logic        e_we;
    logic        e_oe;
    logic [7:0]  e_din;
    logic [7:0]  e_cpu_din;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Advance one clock; the phase counter moves just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    nes_ce = nes_ce + 2'd1;
    #1;
  endtask

  task automatic goto_phase(input logic [1:0] ph);
    int n;
    n = 0;
    while (nes_ce != ph && n < 8) begin
      step();
      n++;
    end
    if (nes_ce !== ph) chk("phase_sync", {30'd0, nes_ce}, {30'd0, ph});
  endtask

  initial begin
    int cnt0, cnt1;
    vt[0] = '{22'h3FFFFF, 1'b1, 1'b0, 8'h00, 8'h5A, 25'h03FFFFF, 1'b0, 1'b1, 8'h00, 8'h5A};
    vt[1] = '{22'h000000, 1'b0, 1'b1, 8'hC3, 8'h00, 25'h0000000, 1'b1, 1'b0, 8'hC3, 8'h00};
    vt[2] = '{22'h2AAAAA, 1'b1, 1'b0, 8'hFF, 8'h81, 25'h02AAAAA, 1'b0, 1'b1, 8'hFF, 8'h81};
    vt[3] = '{22'h155555, 1'b0, 1'b0, 8'h3C, 8'h7E, 25'h0155555, 1'b0, 1'b0, 8'h3C, 8'h7E};
    vt[4] = '{22'h012345, 1'b0, 1'b1, 8'h01, 8'hFF, 25'h0012345, 1'b1, 1'b0, 8'h01, 8'hFF};

    // Reset state
    step();
    step();
    chk("rst_owner", owner0, 0);
    chk("rst_ld_full", ld_full0, 0);
    chk("rst_overrun", ld_overrun0, 0);
    chk("rst_bk_ack", bk_ack0, 0);
    chk("rst_bk_dout", bk_dout0, 0);
    chk("rst_mem_we", mem_we0, 0);
    chk("rst_mem_oe", mem_oe0, 0);
    chk("rst_mem_addr", mem_addr0, 0);
    chk("rst_mem_din", mem_din0, 0);
    chk("rst_owner1", owner1, 0);
    reset_n = 1'b1;

    // Single loader write
    goto_phase(1);
    ld_addr = 22'h000010; ld_data = 8'hA5; ld_wr = 1'b1;
    step();
    ld_wr = 1'b0;
    chk("t1_ld_full_set", ld_full0, 1);
    goto_phase(0);
    for (int c = 0; c < 4; c++) begin
      chk("t1_owner", owner0, 2);
      chk("t1_mem_we", mem_we0, 1);
      chk("t1_mem_oe", mem_oe0, 0);
      chk("t1_mem_addr", mem_addr0, 25'h10);
      chk("t1_mem_din", mem_din0, 8'hA5);
      step();
    end
    chk("t1_we_after", mem_we0, 0);
    chk("t1_owner_after", owner0, 0);
    chk("t1_ld_full_clr", ld_full0, 0);
    chk("t1_addr_hold", mem_addr0, 25'h10);

    // Overrun: second write two cycles later is dropped
    ld_addr = 22'h000020; ld_data = 8'h11; ld_wr = 1'b1;
    step();
    ld_wr = 1'b0;
    step();
    ld_addr = 22'h000030; ld_data = 8'h22; ld_wr = 1'b1;
    step();
    ld_wr = 1'b0;
    chk("t2_overrun", ld_overrun0, 1);
    chk("t2_ld_full", ld_full0, 1);
    step();
    chk("t2_owner", owner0, 2);
    chk("t2_mem_addr", mem_addr0, 25'h20);
    chk("t2_mem_din", mem_din0, 8'h11);
    goto_phase(3);
    chk("t2_mem_din_end", mem_din0, 8'h11);
    step();
    chk("t2_owner_after", owner0, 0);

    // Loader and backup read pending together
    step();
    ld_addr = 22'h000040; ld_data = 8'h33; ld_wr = 1'b1;
    bk_req = 1'b1; bk_we = 1'b0; bk_addr = 22'h3F0000; bk_din = 8'h00;
    step();
    ld_wr = 1'b0;
    goto_phase(0);
    chk("t3_owner_ld0", owner0, 2);
    chk("t3_owner_ld1", owner1, 2);
    chk("t3_ld_addr", mem_addr0, 25'h40);
    mem_dout = 8'hEE;
    goto_phase(3);
    step();
    chk("t3_owner_bk0", owner0, 3);
    chk("t3_owner_bk1", owner1, 3);
    chk("t3_bk_addr", mem_addr0, 25'h3F0000);
    chk("t3_bk_oe", mem_oe0, 1);
    chk("t3_bk_we", mem_we0, 0);
    chk("t3_cpu_din", cpu_din0, 8'hEE);
    chk("t3_ack_early", bk_ack0, 0);
    goto_phase(3);
    chk("t3_bk_oe_end", mem_oe0, 1);
    mem_dout = 8'h5C;
    step();
    chk("t3_ack0", bk_ack0, 1);
    chk("t3_ack1", bk_ack1, 1);
    chk("t3_bk_dout0", bk_dout0, 8'h5C);
    chk("t3_bk_dout1", bk_dout1, 8'h5C);
    chk("t3_owner_idle", owner0, 0);
    bk_req = 1'b0;
    mem_dout = 8'h12;
    step();
    chk("t3_ack_pulse", bk_ack0, 0);

    // Both pending again: round-robin now favours backup, priority keeps loader
    ld_addr = 22'h000050; ld_data = 8'h44; ld_wr = 1'b1;
    bk_req = 1'b1; bk_we = 1'b1; bk_addr = 22'h000123; bk_din = 8'h77;
    step();
    ld_wr = 1'b0;
    goto_phase(3);
    step();
    chk("t4_s1_owner0", owner0, 3);
    chk("t4_s1_owner1", owner1, 2);
    chk("t4_s1_addr0", mem_addr0, 25'h123);
    chk("t4_s1_din0", mem_din0, 8'h77);
    chk("t4_s1_we0", mem_we0, 1);
    chk("t4_s1_oe0", mem_oe0, 0);
    chk("t4_s1_addr1", mem_addr1, 25'h50);
    chk("t4_s1_din1", mem_din1, 8'h44);
    goto_phase(3);
    step();
    chk("t4_s2_owner0", owner0, 2);
    chk("t4_s2_owner1", owner1, 3);
    chk("t4_s2_ack0", bk_ack0, 1);
    chk("t4_s2_ack1", bk_ack1, 0);
    chk("t4_s2_addr0", mem_addr0, 25'h50);
    chk("t4_s2_addr1", mem_addr1, 25'h123);
    chk("t4_s2_we1", mem_we1, 1);
    chk("t4_s2_oe1", mem_oe1, 0);
    goto_phase(3);
    step();
    chk("t4_s3_owner0", owner0, 3);
    chk("t4_s3_owner1", owner1, 0);
    chk("t4_s3_ack1", bk_ack1, 1);
    chk("t4_s3_ack0", bk_ack0, 0);
    bk_req = 1'b0;
    goto_phase(3);
    step();
    chk("t4_s4_owner0", owner0, 0);
    chk("t4_s4_ack0", bk_ack0, 1);
    chk("t4_bk_dout_kept", bk_dout1, 8'h5C);

    // nes_running rises during a backup write slot
    step();
    bk_req = 1'b1; bk_we = 1'b1; bk_addr = 22'h0002AA; bk_din = 8'h99;
    goto_phase(3);
    step();
    cnt0 = 0;
    cnt1 = 0;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) nes_running = 1'b1;
      #1;
      chk("t5_owner_bk", owner0, 3);
      if (mem_we0 && !mem_oe0 && mem_addr0 == 25'h2AA && mem_din0 == 8'h99) cnt0++;
      if (mem_we1 && !mem_oe1 && mem_addr1 == 25'h2AA && mem_din1 == 8'h99) cnt1++;
      step();
    end
    chk("t5_we_cycles0", cnt0, 4);
    chk("t5_we_cycles1", cnt1, 4);
    chk("t5_ack0", bk_ack0, 1);
    chk("t5_ack1", bk_ack1, 1);
    chk("t5_owner_cpu0", owner0, 1);
    chk("t5_owner_cpu1", owner1, 1);
    chk("t5_bk_dout_write", bk_dout0, 8'h5C);
    bk_req = 1'b0;

    // CPU passthrough vectors
    for (int i = 0; i < 5; i++) begin
      cpu_addr = vt[i].addr; cpu_rd = vt[i].rd; cpu_wr = vt[i].wr;
      cpu_dout = vt[i].dout; mem_dout = vt[i].mdout;
      #1;
      chk($sformatf("vec%0d_owner", i), owner0, 1);
      chk($sformatf("vec%0d_addr", i), mem_addr0, vt[i].e_addr);
      chk($sformatf("vec%0d_we", i), mem_we0, vt[i].e_we);
      chk($sformatf("vec%0d_oe", i), mem_oe0, vt[i].e_oe);
      chk($sformatf("vec%0d_din", i), mem_din0, vt[i].e_din);
      chk($sformatf("vec%0d_cpu_din", i), cpu_din0, vt[i].e_cpu_din);
      step();
    end

    // nes_running falls mid-slot: CPU keeps the remainder
    goto_phase(1);
    nes_running = 1'b0; cpu_rd = 1'b0; cpu_wr = 1'b0;
    step();
    chk("t7_owner_keep", owner0, 1);
    goto_phase(3);
    chk("t7_owner_keep_end", owner0, 1);
    step();
    chk("t7_owner_idle0", owner0, 0);
    chk("t7_owner_idle1", owner1, 0);
    chk("t7_we_idle", mem_we0, 0);
    chk("t7_oe_idle", mem_oe0, 0);

    // Asynchronous reset mid loader slot
    step();
    ld_addr = 22'h000060; ld_data = 8'h55; ld_wr = 1'b1;
    step();
    ld_wr = 1'b0;
    goto_phase(3);
    step();
    step();
    chk("t6_owner_ld", owner0, 2);
    chk("t6_we_ld", mem_we0, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_we", mem_we0, 0);
    chk("t6_rst_owner", owner0, 0);
    chk("t6_rst_ld_full", ld_full0, 0);
    chk("t6_rst_overrun", ld_overrun0, 0);
    chk("t6_rst_addr", mem_addr0, 0);
    chk("t6_rst_we1", mem_we1, 0);
    step();
    reset_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_porta_arbiter.md
Name: sdram_porta_arbiter

Overview:
- Owns SDRAM port A and shares it between three requesters: the NES CPU, the GameLoader write stream, and a new battery-RAM backup port that moves save RAM to and from the SD card.
- Access ownership is granted in slots. Each slot is one nes_ce period (4 clk cycles), aligned to the PPU memory phase.
- The block replaces the ad-hoc loader_write_triggered logic and the downloading/loader_busy muxes on addrA, dinA, weA and oeA.

Parameters:
- ADDR_W, 25: SDRAM port A address width. Requester addresses are 22 bits and are zero-extended.
- LOADER_PRIO, 0: 0 = round-robin between loader and backup; 1 = loader always wins over backup.

Ports:
- clk  in  1  system clock (21 MHz NES clock)
- reset_n  in  1  asynchronous, active-low reset
- nes_ce  in  2  NES phase counter; value 3 marks the last cycle of a slot
- nes_running  in  1  high when the NES core is out of reset (~reset_nes)
- cpu_addr  in  22  CPU memory address
- cpu_rd  in  1  CPU read request
- cpu_wr  in  1  CPU write request
- cpu_dout  in  8  CPU write data
- cpu_din  out  8  CPU read data
- ld_wr  in  1  one-cycle loader write strobe
- ld_addr  in  22  loader write address
- ld_data  in  8  loader write data
- ld_full  out  1  loader holding register is occupied
- ld_overrun  out  1  sticky: a loader write was dropped
- bk_req  in  1  backup request level, held until bk_ack
- bk_we  in  1  backup direction: 1 = write to SDRAM, 0 = read
- bk_addr  in  22  backup address
- bk_din  in  8  backup write data
- bk_dout  out  8  backup read data
- bk_ack  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_W  SDRAM port A address
- mem_we  out  1  SDRAM port A write enable
- mem_oe  out  1  SDRAM port A output enable
- mem_din  out  8  SDRAM port A write data
- mem_dout  in  8  SDRAM port A read data
- owner  out  2  current slot owner, for debug

Behaviour:
- Reset values (reset_n low): owner=IDLE, ld_full=0, ld_overrun=0, bk_ack=0, bk_dout=0, mem_we=0, mem_oe=0, mem_addr=0, mem_din=0, round-robin pointer=LOADER. Reset is asynchronous and drops any in-flight slot.
- Owner encoding: IDLE=0, CPU=1, LOADER=2, BACKUP=3.
- Owner register updates only on a clk edge where nes_ce==3. The new owner holds for the following 4 cycles, so the latency from grant to SDRAM command is 1 cycle.
- Grant rules, evaluated at the nes_ce==3 edge:
  - nes_running=1: owner=CPU unconditionally.
  - nes_running=0 with both loader and backup pending: LOADER_PRIO=1 gives LOADER; LOADER_PRIO=0 gives the pointer's side, and the pointer then flips to the other requester.
  - nes_running=0 with one pending: that one.
  - nes_running=0 with none pending: IDLE.
- CPU slot: pure combinational passthrough.
  - mem_addr={0, cpu_addr}, mem_we=cpu_wr, mem_oe=cpu_rd, mem_din=cpu_dout.
  - cpu_din=mem_dout in every slot; CPU timing is unchanged from today.
- LOADER slot:
  - mem_addr and mem_din come from the holding register; mem_we=1 for all 4 cycles; mem_oe=0.
  - ld_full clears on the slot-ending nes_ce==3 edge.
- BACKUP slot:
  - mem_addr and mem_din come from bk_addr/bk_din, sampled at grant; mem_we=bk_we, mem_oe=~bk_we, both for all 4 cycles.
  - On the slot-ending nes_ce==3 edge, bk_dout<=mem_dout (reads only) and bk_ack<=1; bk_ack is 0 on the next cycle.
  - The requester must drop bk_req or present a new request on the cycle after bk_ack; a still-high bk_req is treated as a new request.
- IDLE slot: mem_we=0, mem_oe=0; mem_addr holds its last value.
- Loader holding register:
  - ld_wr with ld_full=0 captures addr/data and sets ld_full.
  - ld_wr with ld_full=1 drops the write and sets ld_overrun, which clears only on reset.
  - ld_wr on the same edge that ld_full clears is captured, not dropped; clear and set resolve to ld_full=1.
- nes_running transitions:
  - Low→high mid-slot: a LOADER or BACKUP slot in progress completes; CPU owns from the next boundary. A pending ld_full or bk_req is retained.
  - High→low mid-slot: CPU keeps the rest of its slot.
- Non-CPU slots never issue both mem_we and mem_oe.

Decomposition:
- Shared package nes_mem_pkg holds: typedef owner_t (IDLE/CPU/LOADER/BACKUP), SLOT_END_PHASE=2'd3, NES_ADDR_W=22.
- One sub-module, porta_slot_timer: registers the nes_ce==3 boundary and generates slot_start/slot_end strobes.
- Grant logic and the muxes stay in the top module.

Test Plan:
- Reset, nes_running=0, single ld_wr (addr=22'h000010, data=8'hA5) at nes_ce=1 → owner=LOADER from the next boundary; mem_we=1 with mem_addr=25'h10 and mem_din=8'hA5 for exactly 4 cycles; ld_full then 0.
- Two ld_wr strobes 2 cycles apart before a boundary → second write dropped; ld_overrun=1; only the first write appears on the port.
- nes_running=0, ld_full and bk_req (read, addr=22'h3F0000) pending together, LOADER_PRIO=0 → LOADER slot, then BACKUP slot; bk_dout equals mem_dout sampled at that slot's nes_ce==3; bk_ack is a 1-cycle pulse.
- Same stimulus with LOADER_PRIO=1 and a continuous ld_wr stream at 1 per 8 cycles → BACKUP is granted only in slots where ld_full=0.
- nes_running rises during cycle 1 of a BACKUP write slot → slot completes with 4 mem_we cycles and bk_ack; next slot owner=CPU; cpu_rd/cpu_addr pass to mem_oe/mem_addr combinationally.
- reset_n pulsed low mid LOADER slot → mem_we=0 immediately (asynchronous); ld_full=0; owner=IDLE.
